// File: rtl/avr_pkg.sv
// avr_pkg: shared definitions for the AVR fetch/sequencer slice.
//   - pc_src_e    : fetch PC select encodings
//   - seq_state_e : sequencer FSM states
//   - opcode mask/match pairs for RJMP, BRBS/BRBC, JMP, LD X, ST X
//   - sreg_bit_e  : SREG bit positions {I,T,H,S,V,N,Z,C}
package avr_pkg;

    typedef enum logic [2:0] {
        PC_ZERO = 3'b000,
        PC_HOLD = 3'b001,
        PC_INC  = 3'b010,
        PC_INC2 = 3'b011,
        PC_REL  = 3'b100,
        PC_ABS  = 3'b101
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_JMP2,
        ST_MEM_WAIT
    } seq_state_e;

    localparam logic [15:0] RJMP_MASK  = 16'hF000;
    localparam logic [15:0] RJMP_MATCH = 16'hC000;
    localparam logic [15:0] BRBX_MASK  = 16'hF800;
    localparam logic [15:0] BRBX_MATCH = 16'hF000;
    localparam logic [15:0] JMP_MASK   = 16'hFE0E;
    localparam logic [15:0] JMP_MATCH  = 16'h940C;
    localparam logic [15:0] LDX_MASK   = 16'hFE0F;
    localparam logic [15:0] LDX_MATCH  = 16'h900C;
    localparam logic [15:0] STX_MASK   = 16'hFE0F;
    localparam logic [15:0] STX_MATCH  = 16'h920C;

    typedef enum int {
        SREG_C = 0,
        SREG_Z = 1,
        SREG_N = 2,
        SREG_V = 3,
        SREG_S = 4,
        SREG_H = 5,
        SREG_T = 6,
        SREG_I = 7
    } sreg_bit_e;

    function automatic logic op_match(input logic [15:0] instr,
                                      input logic [15:0] mask,
                                      input logic [15:0] match);
        return (instr & mask) == match;
    endfunction

endpackage

// File: rtl/avr_seq_ctrl_if.sv
// avr_seq_ctrl_if: sequencer <-> fetch/CPU/data-memory signal bundle.
//   instr, sreg, mem_ack                         : into the sequencer
//   pc_src, jmp, exec_valid, mem_req, mem_we,
//   mem_err                                      : out of the sequencer
// slave  = sequencer side, master = environment (fetch/CPU/memory) side.
interface avr_seq_ctrl_if;
    logic [15:0] instr;
    logic [7:0]  sreg;
    logic        mem_ack;
    logic [2:0]  pc_src;
    logic [15:0] jmp;
    logic        exec_valid;
    logic        mem_req;
    logic        mem_we;
    logic        mem_err;

    modport slave (
        input  instr, sreg, mem_ack,
        output pc_src, jmp, exec_valid, mem_req, mem_we, mem_err
    );

    modport master (
        output instr, sreg, mem_ack,
        input  pc_src, jmp, exec_valid, mem_req, mem_we, mem_err
    );
endinterface

// File: rtl/avr_br_decode.sv
// avr_br_decode: combinational classifier for the control-flow and
// memory opcodes the sequencer cares about.
//   instr_i    : held instruction word
//   sreg_i     : status register
//   is_rjmp_o  : RJMP k12
//   is_br_o    : BRBS/BRBC s,k7
//   br_taken_o : branch condition true
//   rel_off_o  : sign-extended k (k12 for RJMP, k7 for branch) + 1
//   is_jmp_o   : first word of two-word JMP
//   is_ld_o    : LD Rd,X
//   is_st_o    : ST X,Rr
module avr_br_decode
    import avr_pkg::*;
(
    input  logic [15:0] instr_i,
    input  logic [7:0]  sreg_i,
    output logic        is_rjmp_o,
    output logic        is_br_o,
    output logic        br_taken_o,
    output logic [15:0] rel_off_o,
    output logic        is_jmp_o,
    output logic        is_ld_o,
    output logic        is_st_o
);
    logic [15:0] k12_ext;
    logic [15:0] k7_ext;

    assign is_rjmp_o = op_match(instr_i, RJMP_MASK, RJMP_MATCH);
    assign is_br_o   = op_match(instr_i, BRBX_MASK, BRBX_MATCH);
    assign is_jmp_o  = op_match(instr_i, JMP_MASK,  JMP_MATCH);
    assign is_ld_o   = op_match(instr_i, LDX_MASK,  LDX_MATCH);
    assign is_st_o   = op_match(instr_i, STX_MASK,  STX_MATCH);

    // instr[10] = 0 is BRBS (taken on bit set), 1 is BRBC (taken on bit clear)
    assign br_taken_o = (sreg_i[instr_i[2:0]] == ~instr_i[10]);

    assign k12_ext = {{4{instr_i[11]}}, instr_i[11:0]};
    assign k7_ext  = {{9{instr_i[9]}},  instr_i[9:3]};

    // Fetch adds this to the PC of the current word, so +1 lands on PC+k+1
    assign rel_off_o = (is_br_o ? k7_ext : k12_ext) + 16'd1;
endmodule

// File: rtl/avr_seq_ctrl.sv
// avr_seq_ctrl: per-cycle sequencer between fetch and the CPU core.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : avr_seq_ctrl_if.slave (instr/sreg/mem_ack in;
//              pc_src/jmp/exec_valid/mem_req/mem_we/mem_err out)
// Outputs other than mem_err are combinational from state, instr and sreg
// because fetch consumes them in the same cycle.
// TW must satisfy 2**TW > MEM_TIMEOUT.
module avr_seq_ctrl
    import avr_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 4
) (
    input  logic           CLK,
    input  logic           RST,
    avr_seq_ctrl_if.slave  bus
);
    seq_state_e  state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic        mem_err_q, mem_err_d;

    pc_src_e     pc_src;
    logic [15:0] jmp;
    logic        exec_valid, mem_req, mem_we;

    logic        is_rjmp, is_br, br_taken, is_jmp, is_ld, is_st;
    logic [15:0] rel_off;
    logic        timeout;

    avr_br_decode u_dec (
        .instr_i    (bus.instr),
        .sreg_i     (bus.sreg),
        .is_rjmp_o  (is_rjmp),
        .is_br_o    (is_br),
        .br_taken_o (br_taken),
        .rel_off_o  (rel_off),
        .is_jmp_o   (is_jmp),
        .is_ld_o    (is_ld),
        .is_st_o    (is_st)
    );

    assign timeout = (cnt_q == TW'(MEM_TIMEOUT));

    always_comb begin
        pc_src     = PC_ZERO;
        jmp        = 16'h0000;
        exec_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_err_d  = mem_err_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (is_rjmp) begin
                    pc_src     = PC_REL;
                    jmp        = rel_off;
                    exec_valid = 1'b1;
                end else if (is_br) begin
                    exec_valid = 1'b1;
                    if (br_taken) begin
                        pc_src = PC_REL;
                        jmp    = rel_off;
                    end else begin
                        pc_src = PC_INC;
                    end
                end else if (is_jmp) begin
                    pc_src  = PC_INC;
                    state_d = ST_JMP2;
                end else if (is_ld || is_st) begin
                    // Hold fetch so instr stays put for the whole access
                    mem_req = 1'b1;
                    mem_we  = bus.instr[9];
                    pc_src  = PC_HOLD;
                    cnt_d   = '0;
                    state_d = ST_MEM_WAIT;
                end else begin
                    pc_src     = PC_INC;
                    exec_valid = 1'b1;
                end
            end
            ST_JMP2: begin
                pc_src     = PC_ABS;
                jmp        = bus.instr;
                exec_valid = 1'b1;
                state_d    = ST_RUN;
            end
            ST_MEM_WAIT: begin
                mem_req = 1'b1;
                mem_we  = bus.instr[9];
                if (bus.mem_ack) begin
                    // Ack beats a coincident timeout
                    pc_src     = PC_INC;
                    exec_valid = 1'b1;
                    state_d    = ST_RUN;
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    pc_src    = PC_INC;
                    state_d   = ST_RUN;
                end else begin
                    pc_src = PC_HOLD;
                    cnt_d  = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Reset masks the combinational outputs immediately, so an
        // in-flight request drops in the same cycle.
        if (RST) begin
            pc_src     = PC_ZERO;
            jmp        = 16'h0000;
            exec_valid = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_BOOT;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign bus.pc_src     = pc_src;
    assign bus.jmp        = jmp;
    assign bus.exec_valid = exec_valid;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.mem_err    = mem_err_q;
endmodule
